// File: rtl/mem_bank_param.sv
// Parametrised single-port memory bank: registered 1-cycle reads, write-through,
// self-clearing sweep after reset, and a tri-state output shared on the data bus.
module mem_bank_param #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  di,
    output logic [WIDTH-1:0]  dout,
    output logic              valid,
    output logic              busy
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  clr_ptr;
    logic [ADDR_W-1:0]  clr_ptr_nxt;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [WIDTH-1:0]   rdata;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [WIDTH-1:0]   mem_wdata;
    logic               acc;

    // Next state, sweep pointer and the single shared write port.
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = di;
        acc         = 1'b0;
        if (rst) begin
            state_nxt   = CLEAR;
            clr_ptr_nxt = '0;
        end else begin
            case (state)
                CLEAR: begin
                    mem_we      = 1'b1;
                    mem_waddr   = clr_ptr;
                    mem_wdata   = '0;
                    clr_ptr_nxt = clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    if (cs) begin
                        acc    = 1'b1;
                        mem_we = we;
                    end
                end
                default: begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // busy tracks the state being entered so it drops the cycle after the last clear write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b1;
            valid <= 1'b0;
            rdata <= '0;
        end else begin
            busy  <= (state_nxt == CLEAR);
            valid <= acc;
            if (acc) begin
                rdata <= we ? di : mem[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dout = (oe && !busy) ? rdata : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bank_param.sv
// Directed bench for mem_bank_param: vector table for steady-state accesses plus
// hand sequences for the reset sweep, ignored accesses and mid-sweep reset.
module tb_mem_bank_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       we;
    logic       oe;
    logic [3:0] addr;
    logic [7:0] di;
    logic       valid;
    logic       busy;
    logic       bus_drv;
    wire  [7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    // Another bank on the shared bus pulls it to 8'h00 whenever this bank's oe is low.
    assign dout = bus_drv ? 8'h00 : 8'bzzzz_zzzz;

    mem_bank_param #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .we    (we),
        .oe    (oe),
        .addr  (addr),
        .di    (di),
        .dout  (dout),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cs;
        logic       we;
        logic       oe;
        logic [3:0] addr;
        logic [7:0] di;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic c, input logic w, input logic o,
                                input logic [3:0] a, input logic [7:0] d,
                                input logic v, input logic [7:0] e);
        vec_t t;
        t.cs = c; t.we = w; t.oe = o; t.addr = a; t.di = d; t.ev = v; t.ed = e;
        vecs.push_back(t);
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic c, input logic w, input logic o,
                         input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = c; we = w; oe = o; addr = a; di = d; bus_drv = !o;
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges until busy falls; optionally injects a write on sweep edge 2.
    task automatic wait_sweep(input bit inject, output int cnt);
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            check("sweep_valid", 8'(valid), 8'h00);
            if (inject && cnt == 2) begin
                cs = 1'b1; we = 1'b1; addr = 4'hF; di = 8'hFF;
            end
            if (!busy) break;
        end
        cs = 1'b0; we = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b0; addr = '0; di = '0; bus_drv = 1'b1;

        // Reset held two cycles, then a full sweep with an ignored write on cycle 2.
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 8'(busy), 8'h01);
        check("reset_valid", 8'(valid), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wait_sweep(1'b1, cnt);
        check("sweep_len", 8'(cnt), 8'd16);

        for (int i = 0; i < 16; i++) add(1, 0, 1, 4'(i), 8'h00, 1, 8'h00);
        add(1, 1, 0, 4'h3, 8'hA5, 1, 8'h00);
        add(1, 0, 1, 4'h3, 8'h00, 1, 8'hA5);
        add(1, 0, 0, 4'h3, 8'h00, 1, 8'h00);
        add(0, 0, 1, 4'h0, 8'h11, 0, 8'hA5);
        add(1, 1, 1, 4'h7, 8'h3C, 1, 8'h3C);
        add(1, 0, 1, 4'h0, 8'h00, 1, 8'h00);
        add(1, 0, 1, 4'h7, 8'h00, 1, 8'h3C);
        add(1, 1, 0, 4'h9, 8'h77, 1, 8'h00);
        add(1, 0, 1, 4'h9, 8'h00, 1, 8'h77);
        for (int i = 0; i < 16; i++) add(1, 1, 1, 4'(i), 8'(i) ^ 8'h5A, 1, 8'(i) ^ 8'h5A);
        for (int i = 0; i < 16; i++) add(1, 0, 1, 4'(i), 8'h00, 1, 8'(i) ^ 8'h5A);

        foreach (vecs[k]) begin
            apply(vecs[k].cs, vecs[k].we, vecs[k].oe, vecs[k].addr, vecs[k].di);
            check($sformatf("vec%0d_valid", k), 8'(valid), 8'(vecs[k].ev));
            check($sformatf("vec%0d_dout", k), dout, vecs[k].ed);
        end

        // Reset, restart mid-sweep at cycle 8 with a read pending, then full sweep.
        @(negedge clk);
        cs = 1'b0; oe = 1'b1; bus_drv = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("mid_busy", 8'(busy), 8'h01);
        end
        @(negedge clk);
        rst = 1'b1; cs = 1'b1; we = 1'b0; addr = 4'h5;
        @(posedge clk);
        #1;
        check("rst_pulse_busy", 8'(busy), 8'h01);
        check("rst_pulse_valid", 8'(valid), 8'h00);
        @(negedge clk);
        rst = 1'b0; cs = 1'b0;
        wait_sweep(1'b0, cnt);
        check("restart_len", 8'(cnt), 8'd16);

        for (int i = 0; i < 16; i++) begin
            apply(1, 0, 1, 4'(i), 8'h00);
            check($sformatf("clr_valid%0d", i), 8'(valid), 8'h01);
            check($sformatf("clr_dout%0d", i), dout, 8'h00);
        end
        apply(0, 0, 1, 4'h0, 8'h00);
        check("idle_valid", 8'(valid), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
